// File: rtl/tqvp_htfab_vga_capture.sv
// tqvp_htfab_vga_capture: 1-bit VGA receiver with timing measurement and 32x8 snapshot capture
module tqvp_htfab_vga_capture #(
  parameter int DEF_H_OFF = 144,
  parameter int DEF_PIX_DIV = 20,
  parameter int DEF_V_OFF = 35,
  parameter int DEF_LINE_STEP = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  typedef enum logic [2:0] {IDLE, ARMED, VWAIT, HWAIT, SAMPLE} state_t;
  localparam logic [30:0] CFG_RST = {6'(DEF_LINE_STEP), 10'(DEF_V_OFF), 5'(DEF_PIX_DIV), 10'(DEF_H_OFF)};
  state_t state, state_nx;
  logic hs_prev, vs_prev, irq_en, done, err;
  logic [15:0] clk_cnt, period;
  logic [10:0] line_cnt, lines, line, target, tgt_nx;
  logic [30:0] cfg;
  logic [9:0] cnt;
  logic [4:0] idx, pix_div;
  logic [5:0] line_step;
  logic [2:0] row;
  logic [31:0] sbuf, row_data, rdata;
  logic [31:0] rows [8];
  logic hs_fall, vs_fall, we, ctrl_wr, arm, clr, tick, start, take, commit, fin, abort, armed, capturing;
  logic unused_bits;
  assign uo_out = 8'b0;
  assign unused_bits = &{1'b0, ui_in[7:3], data_in[31]};
  assign hs_fall = hs_prev & ~ui_in[1];
  assign vs_fall = vs_prev & ~ui_in[2];
  assign we = data_write_n == 2'b10;
  assign ctrl_wr = we && address == 6'h20;
  assign arm = ctrl_wr && data_in[0] && state == IDLE;
  assign clr = ctrl_wr & data_in[2];
  assign pix_div = cfg[14:10] == 5'd0 ? 5'd1 : cfg[14:10];
  assign line_step = cfg[30:25] == 6'd0 ? 6'd1 : cfg[30:25];
  assign target = 11'(cfg[24:15]) + 11'(row) * 11'(line_step);
  assign tgt_nx = target + 11'(line_step);
  assign tick = cnt <= 10'd1;
  assign row_data = take ? sbuf | (32'(ui_in[0]) << idx) : sbuf;
  assign armed = state == ARMED;
  assign capturing = state != IDLE && state != ARMED;
  assign user_interrupt = done & irq_en;
  assign rdata = (!address[5] && address[1:0] == 2'b00) ? rows[address[4:2]] :
                 address == 6'h20 ? {27'b0, irq_en, err, done, capturing, armed} :
                 address == 6'h24 ? {16'b0, period} :
                 address == 6'h28 ? {21'b0, lines} :
                 address == 6'h2C ? {1'b0, cfg} : 32'b0;
  // sync edge history; idle-high so reset never fakes a falling edge
  always_ff @(posedge clk) begin
    hs_prev <= !rst_n | ui_in[1];
    vs_prev <= !rst_n | ui_in[2];
  end
  // free-running line period and lines-per-frame measurement, saturating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt <= 16'd0;
      period <= 16'd0;
      line_cnt <= 11'd0;
      lines <= 11'd0;
    end else begin
      clk_cnt <= hs_fall ? 16'd1 : &clk_cnt ? clk_cnt : clk_cnt + 16'd1;
      if (hs_fall) period <= clk_cnt;
      line_cnt <= vs_fall ? {10'd0, hs_fall} : (hs_fall && !(&line_cnt)) ? line_cnt + 11'd1 : line_cnt;
      if (vs_fall) lines <= line_cnt;
    end
  end
  // register bus: config/irq_en writes and one-cycle-latency reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg <= CFG_RST;
      irq_en <= 1'b0;
      data_ready <= 1'b0;
      data_out <= 32'b0;
    end else begin
      if (we && address == 6'h2C) cfg <= data_in[30:0];
      if (ctrl_wr) irq_en <= data_in[1];
      data_ready <= data_read_n != 2'b11;
      if (data_read_n != 2'b11) data_out <= rdata;
    end
  end
  // capture state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  // capture sequencing; an hsync fall cuts a row short and may start the next one
  always_comb begin
    state_nx = state;
    start = 1'b0;
    take = 1'b0;
    commit = 1'b0;
    fin = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: state_nx = arm ? ARMED : IDLE;
      ARMED: state_nx = vs_fall ? VWAIT : ARMED;
      default:
        if (vs_fall) begin
          abort = 1'b1;
          state_nx = IDLE;
        end else if (hs_fall && state == VWAIT) begin
          start = line == target;
          state_nx = start ? HWAIT : VWAIT;
        end else if (hs_fall) begin
          commit = 1'b1;
          fin = row == 3'd7;
          start = !fin && line == tgt_nx;
          state_nx = fin ? IDLE : start ? HWAIT : VWAIT;
        end else if (state != VWAIT && tick) begin
          take = 1'b1;
          commit = state == SAMPLE && idx == 5'd31;
          fin = commit && row == 3'd7;
          state_nx = fin ? IDLE : commit ? VWAIT : SAMPLE;
        end
    endcase
  end
  // capture datapath: line/row tracking, sample timer, row buffer and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done <= 1'b0;
      err <= 1'b0;
      line <= 11'd0;
      row <= 3'd0;
      cnt <= 10'd0;
      idx <= 5'd0;
      sbuf <= 32'b0;
      for (int i = 0; i < 8; i++) rows[i] <= 32'b0;
    end else begin
      done <= (fin | abort) ? 1'b1 : (clr | arm) ? 1'b0 : done;
      err <= abort ? 1'b1 : (clr | arm) ? 1'b0 : err;
      line <= (armed && vs_fall) ? 11'd0 : hs_fall ? line + 11'd1 : line;
      row <= (armed && vs_fall) ? 3'd0 : (commit && !fin) ? row + 3'd1 : row;
      if (start) begin
        cnt <= cfg[9:0];
        idx <= 5'd0;
        sbuf <= 32'b0;
      end else if (take) begin
        cnt <= 10'(pix_div);
        idx <= idx + 5'd1;
        sbuf <= row_data;
      end else if (cnt != 10'd0) cnt <= cnt - 10'd1;
      if (arm) for (int i = 0; i < 8; i++) rows[i] <= 32'b0;
      else if (commit) rows[row] <= row_data;
    end
  end
endmodule

// File: tb/tb_tqvp_htfab_vga_capture.sv
// tb_tqvp_htfab_vga_capture: scoreboard bench for the VGA capture peripheral
module tb_tqvp_htfab_vga_capture;
  localparam logic [31:0] CFG_DEF = (60 << 25) | (35 << 15) | (20 << 10) | 144;
  localparam logic [31:0] CFG_T = (1 << 25) | (3 << 15) | (2 << 10) | 10;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] ui_in = 8'h06;
  logic [7:0] uo_out;
  logic [5:0] address = 6'd0;
  logic [31:0] data_in = 32'd0;
  logic [1:0] data_write_n = 2'b11, data_read_n = 2'b11;
  logic [31:0] data_out;
  logic data_ready, user_interrupt;
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] exp_q[$];
  int due_q[$];
  string name_q[$];
  string mon_nm;

  tqvp_htfab_vga_capture dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // monitor: every data_ready pops one expected read and its due cycle
  always @(negedge clk) begin
    if (data_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected data_ready: data_out 0x%08h with no read pending", data_out);
      end else begin
        mon_nm = name_q.pop_front();
        chk(mon_nm, data_out, exp_q.pop_front());
        chk({mon_nm, " latency"}, 32'(cyc), 32'(due_q.pop_front()));
      end
    end
  end

  task automatic rd(input logic [5:0] a, input logic [31:0] e, input string nm);
    address = a;
    data_read_n = 2'b00;
    exp_q.push_back(e);
    due_q.push_back(cyc + 1);
    name_q.push_back(nm);
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn = 2'b10);
    address = a;
    data_in = d;
    data_write_n = wn;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  function automatic logic pixf(input int mode, input int l, input int p);
    return mode == 1 ? (p >= 10 && (p - 10) % 4 == 0) : mode == 2 ? (l == 5) : (mode == 3);
  endfunction

  // 3-clock vsync pulse, then nl lines of len clocks each starting with a 1-clock hsync pulse
  task automatic frame(input int nl, input int len, input int mode);
    for (int i = 0; i < 3; i++) begin
      ui_in = 8'h02;
      @(negedge clk);
    end
    for (int l = 0; l < nl; l++)
      for (int p = 0; p < len; p++) begin
        ui_in = {5'b0, 1'b1, p != 0, pixf(mode, l, p)};
        @(negedge clk);
      end
    ui_in = 8'h06;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset data_ready", 32'(data_ready), 32'd0);
    chk("reset user_interrupt", 32'(user_interrupt), 32'd0);
    chk("reset uo_out", 32'(uo_out), 32'd0);
    rst_n = 1'b1;
    rd(6'h2C, CFG_DEF, "cfg default");
    rd(6'h20, 32'h0, "status reset");
    rd(6'h24, 32'h0, "period reset");
    rd(6'h28, 32'h0, "lines reset");
    rd(6'h00, 32'h0, "row0 reset");
    wr(6'h2C, 32'h0, 2'b01);
    wr(6'h2C, 32'h0, 2'b00);
    rd(6'h2C, CFG_DEF, "cfg narrow write ignored");
    rd(6'h30, 32'h0, "unmapped");
    frame(525, 20, 0);
    frame(525, 20, 0);
    frame(3, 2000, 0);
    rd(6'h24, 32'd2000, "line period");
    rd(6'h28, 32'd525, "lines per frame");
    wr(6'h24, 32'h1234);
    rd(6'h24, 32'd2000, "ro write ignored");
    wr(6'h2C, CFG_T);
    rd(6'h2C, CFG_T, "cfg write");
    wr(6'h20, 32'h3);
    rd(6'h20, 32'h11, "status armed");
    frame(12, 100, 1);
    rd(6'h20, 32'h14, "status done alt");
    chk("irq alt", 32'(user_interrupt), 32'd1);
    for (int r = 0; r < 8; r++) rd(6'(r * 4), 32'h55555555, $sformatf("alt row%0d", r));
    wr(6'h20, 32'h3);
    frame(12, 100, 2);
    rd(6'h20, 32'h14, "status done line5");
    for (int r = 0; r < 8; r++) rd(6'(r * 4), r == 2 ? 32'hFFFFFFFF : 32'h0, $sformatf("line5 row%0d", r));
    wr(6'h20, 32'h3);
    frame(7, 100, 3);
    frame(0, 100, 0);
    rd(6'h20, 32'h1C, "status abort");
    chk("irq abort", 32'(user_interrupt), 32'd1);
    for (int r = 0; r < 8; r++) rd(6'(r * 4), r < 4 ? 32'hFFFFFFFF : 32'h0, $sformatf("abort row%0d", r));
    wr(6'h20, 32'h4);
    rd(6'h20, 32'h0, "status cleared");
    chk("irq cleared", 32'(user_interrupt), 32'd0);
    wr(6'h20, 32'h3);
    frame(12, 50, 3);
    rd(6'h20, 32'h14, "status short lines");
    for (int r = 0; r < 8; r++) rd(6'(r * 4), 32'h000FFFFF, $sformatf("short row%0d", r));
    rd(6'h24, 32'd50, "short period");
    wr(6'h20, 32'h3);
    frame(6, 100, 3);
    rd(6'h20, 32'h12, "status capturing");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("irq after reset", 32'(user_interrupt), 32'd0);
    rd(6'h20, 32'h0, "status after reset");
    rd(6'h00, 32'h0, "row0 after reset");
    rd(6'h08, 32'h0, "row2 after reset");
    rd(6'h24, 32'h0, "period after reset");
    rd(6'h28, 32'h0, "lines after reset");
    rd(6'h2C, CFG_DEF, "cfg after reset");
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no response expected 0x%08h", name_q.pop_front(), exp_q.pop_front());
      void'(due_q.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
